// File: rtl/combat_manager_pkg.sv
// Shared types and helpers for the combat manager: facing direction,
// enemy slot states, axis-aligned boxes, overlap test and clamped subtract.
package combat_pkg;

    // Box coordinates are carried wider than COORD_W+2 so that no
    // anchor-plus-extent sum can wrap for any sensible coordinate width.
    localparam int BOX_W = 16;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ST_ALIVE = 1'b0,
        ST_DEAD  = 1'b1
    } enemy_state_t;

    // Inclusive box: [l, r] x [t, b]
    typedef struct packed {
        logic [BOX_W-1:0] l;
        logic [BOX_W-1:0] r;
        logic [BOX_W-1:0] t;
        logic [BOX_W-1:0] b;
    } box_t;

    // Touching edges count as overlap.
    function automatic logic boxes_overlap(input box_t a, input box_t b);
        return (a.l <= b.r) && (a.r >= b.l) && (a.t <= b.b) && (a.b >= b.t);
    endfunction

    // Subtraction clamped at zero.
    function automatic logic [BOX_W-1:0] sat_sub(input logic [BOX_W-1:0] a,
                                                 input logic [BOX_W-1:0] b);
        return (a <= b) ? '0 : (a - b);
    endfunction

endpackage

// File: rtl/combat_manager_if.sv
// Bundle of the positional inputs and combat status outputs exchanged
// between the motion blocks, the combat manager and the HUD/renderer.
interface combat_manager_if #(
    parameter int ENEMY_NUM = 4,
    parameter int COORD_W   = 9,
    parameter int HP_W      = 7,
    parameter int SCORE_W   = 10
);
    logic [COORD_W-1:0]           Player_X;
    logic [COORD_W-1:0]           Player_Y;
    logic [COORD_W-1:0]           Attack_X;
    logic [COORD_W-1:0]           Attack_Y;
    logic [1:0]                   Player_Direction;
    logic                         Attack_On;
    logic [ENEMY_NUM*COORD_W-1:0] Enemy_X;
    logic [ENEMY_NUM*COORD_W-1:0] Enemy_Y;
    logic [ENEMY_NUM-1:0]         Enemy_Alive;
    logic [ENEMY_NUM*HP_W-1:0]    Enemy_Blood;
    logic [ENEMY_NUM-1:0]         Enemy_Killed;
    logic [ENEMY_NUM-1:0]         Enemy_Respawn;
    logic [HP_W-1:0]              Player_Blood;
    logic                         Player_Invuln;
    logic                         Game_Over;
    logic [SCORE_W-1:0]           Score;

    modport master (
        output Player_X, Player_Y, Attack_X, Attack_Y, Player_Direction,
               Attack_On, Enemy_X, Enemy_Y,
        input  Enemy_Alive, Enemy_Blood, Enemy_Killed, Enemy_Respawn,
               Player_Blood, Player_Invuln, Game_Over, Score
    );

    modport slave (
        input  Player_X, Player_Y, Attack_X, Attack_Y, Player_Direction,
               Attack_On, Enemy_X, Enemy_Y,
        output Enemy_Alive, Enemy_Blood, Enemy_Killed, Enemy_Respawn,
               Player_Blood, Player_Invuln, Game_Over, Score
    );
endinterface

// File: rtl/combat_manager_enemy_slot.sv
// One enemy slot: health, ALIVE/DEAD state and respawn countdown.
// kill_now is the combinational death event used by the score adder so the
// score moves on the same edge that launches the registered killed pulse.
module combat_manager_enemy_slot
    import combat_pkg::*;
#(
    parameter int HP_W          = 7,
    parameter int MAX_HP        = 100,
    parameter int ATTACK_DMG    = 25,
    parameter int RESPAWN_TICKS = 80
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            hit,
    input  logic            game_over,
    output logic            alive,
    output logic [HP_W-1:0] blood,
    output logic            killed,
    output logic            respawn,
    output logic            kill_now
);
    localparam int CNT_W = $clog2(RESPAWN_TICKS + 1);

    enemy_state_t     state_r, state_s;
    logic [HP_W-1:0]  blood_r, blood_s, hit_blood_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             killed_r, respawn_r, kill_s, resp_s;

    assign hit_blood_s = HP_W'(sat_sub(BOX_W'(blood_r), BOX_W'(ATTACK_DMG)));

    // Next-state: take damage while alive, count down while dead, all frozen in game over
    always_comb begin
        state_s = state_r;
        blood_s = blood_r;
        cnt_s   = cnt_r;
        kill_s  = 1'b0;
        resp_s  = 1'b0;
        if (tick && !game_over) begin
            case (state_r)
                ST_ALIVE: begin
                    if (hit) begin
                        blood_s = hit_blood_s;
                        if (hit_blood_s == '0) begin
                            state_s = ST_DEAD;
                            cnt_s   = CNT_W'(RESPAWN_TICKS);
                            kill_s  = 1'b1;
                        end else begin
                            state_s = ST_ALIVE;
                        end
                    end else begin
                        blood_s = blood_r;
                    end
                end
                ST_DEAD: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_s = ST_ALIVE;
                        blood_s = HP_W'(MAX_HP);
                        cnt_s   = '0;
                        resp_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_ALIVE;
                    blood_s = HP_W'(MAX_HP);
                    cnt_s   = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Slot state register and one-cycle event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_ALIVE;
            blood_r   <= HP_W'(MAX_HP);
            cnt_r     <= '0;
            killed_r  <= 1'b0;
            respawn_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            blood_r   <= blood_s;
            cnt_r     <= cnt_s;
            killed_r  <= kill_s;
            respawn_r <= resp_s;
        end
    end

    assign alive    = (state_r == ST_ALIVE);
    assign blood    = blood_r;
    assign killed   = killed_r;
    assign respawn  = respawn_r;
    assign kill_now = kill_s;

endmodule

// File: rtl/combat_manager.sv
// Combat manager top: frame-tick synchroniser, attack and contact geometry,
// enemy slots, player health/invulnerability, sticky game over and score.
module combat_manager
    import combat_pkg::*;
#(
    parameter int ENEMY_NUM     = 4,
    parameter int COORD_W       = 9,
    parameter int HP_W          = 7,
    parameter int MAX_HP        = 100,
    parameter int ATTACK_DMG    = 25,
    parameter int CONTACT_DMG   = 10,
    parameter int ATTACK_SHORT  = 16,
    parameter int ATTACK_LONG   = 80,
    parameter int ENEMY_W       = 26,
    parameter int ENEMY_H       = 26,
    parameter int PLAYER_W      = 26,
    parameter int PLAYER_H      = 26,
    parameter int RESPAWN_TICKS = 80,
    parameter int INVULN_TICKS  = 30,
    parameter int SCORE_W       = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    combat_manager_if.slave  bus
);
    localparam int INV_W = $clog2(INVULN_TICKS + 1);

    logic                      sync1_r, sync2_r, delay_r, tick_s;
    box_t                      abox_s, pbox_s;
    logic [ENEMY_NUM-1:0]      hit_s, contact_s, alive_s, kill_now_s, killed_s, respawn_s;
    logic [ENEMY_NUM*HP_W-1:0] eblood_s;
    logic [HP_W-1:0]           php_r, php_hit_s;
    logic [INV_W-1:0]          inv_r;
    logic                      game_over_r, contact_now_s;
    logic [SCORE_W-1:0]        score_r, score_next_s;
    logic [SCORE_W:0]          kill_cnt_s, score_sum_s;

    // Bring frame_clk into the Clk domain and keep one delayed copy for edge detect
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            delay_r <= 1'b0;
        end else begin
            sync1_r <= frame_clk;
            sync2_r <= sync1_r;
            delay_r <= sync2_r;
        end
    end

    assign tick_s = sync2_r & ~delay_r;

    // Attack box from the anchor and facing; extents are inclusive and clamp at 0
    always_comb begin
        abox_s.l = BOX_W'(bus.Attack_X);
        abox_s.r = BOX_W'(bus.Attack_X) + BOX_W'(ATTACK_SHORT);
        abox_s.t = BOX_W'(bus.Attack_Y);
        abox_s.b = BOX_W'(bus.Attack_Y) + BOX_W'(ATTACK_LONG);
        case (dir_t'(bus.Player_Direction))
            DIR_DOWN: begin
                abox_s.b = BOX_W'(bus.Attack_Y) + BOX_W'(ATTACK_LONG);
            end
            DIR_LEFT: begin
                abox_s.l = sat_sub(BOX_W'(bus.Attack_X), BOX_W'(ATTACK_LONG));
                abox_s.r = BOX_W'(bus.Attack_X);
                abox_s.b = BOX_W'(bus.Attack_Y) + BOX_W'(ATTACK_SHORT);
            end
            DIR_UP: begin
                abox_s.t = sat_sub(BOX_W'(bus.Attack_Y), BOX_W'(ATTACK_LONG));
                abox_s.b = BOX_W'(bus.Attack_Y);
            end
            DIR_RIGHT: begin
                abox_s.r = BOX_W'(bus.Attack_X) + BOX_W'(ATTACK_LONG);
                abox_s.b = BOX_W'(bus.Attack_Y) + BOX_W'(ATTACK_SHORT);
            end
            default: begin
                abox_s.r = BOX_W'(bus.Attack_X) + BOX_W'(ATTACK_SHORT);
            end
        endcase
    end

    // Player box spans top-left to top-left plus width/height, same convention as the attack box
    always_comb begin
        pbox_s.l = BOX_W'(bus.Player_X);
        pbox_s.r = BOX_W'(bus.Player_X) + BOX_W'(PLAYER_W);
        pbox_s.t = BOX_W'(bus.Player_Y);
        pbox_s.b = BOX_W'(bus.Player_Y) + BOX_W'(PLAYER_H);
    end

    for (genvar i = 0; i < ENEMY_NUM; i++) begin : g_enemy
        box_t ebox_s;

        // Enemy box for this slot
        always_comb begin
            ebox_s.l = BOX_W'(bus.Enemy_X[i*COORD_W +: COORD_W]);
            ebox_s.r = BOX_W'(bus.Enemy_X[i*COORD_W +: COORD_W]) + BOX_W'(ENEMY_W);
            ebox_s.t = BOX_W'(bus.Enemy_Y[i*COORD_W +: COORD_W]);
            ebox_s.b = BOX_W'(bus.Enemy_Y[i*COORD_W +: COORD_W]) + BOX_W'(ENEMY_H);
        end

        // Contact uses pre-tick alive, so a slot killed this tick still hurts the player
        assign hit_s[i]     = bus.Attack_On & boxes_overlap(abox_s, ebox_s);
        assign contact_s[i] = alive_s[i] & boxes_overlap(pbox_s, ebox_s);

        combat_manager_enemy_slot #(
            .HP_W          (HP_W),
            .MAX_HP        (MAX_HP),
            .ATTACK_DMG    (ATTACK_DMG),
            .RESPAWN_TICKS (RESPAWN_TICKS)
        ) u_slot (
            .clk       (Clk),
            .rst_n     (Reset_n),
            .tick      (tick_s),
            .hit       (hit_s[i]),
            .game_over (game_over_r),
            .alive     (alive_s[i]),
            .blood     (eblood_s[i*HP_W +: HP_W]),
            .killed    (killed_s[i]),
            .respawn   (respawn_s[i]),
            .kill_now  (kill_now_s[i])
        );
    end

    assign php_hit_s     = HP_W'(sat_sub(BOX_W'(php_r), BOX_W'(CONTACT_DMG)));
    assign contact_now_s = tick_s & ~game_over_r & (inv_r == '0) & (|contact_s);

    // Player health, invulnerability window and sticky game over
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            php_r       <= HP_W'(MAX_HP);
            inv_r       <= '0;
            game_over_r <= 1'b0;
        end else begin
            if (contact_now_s) begin
                php_r       <= php_hit_s;
                inv_r       <= INV_W'(INVULN_TICKS);
                game_over_r <= game_over_r | (php_hit_s == '0);
            end else if (tick_s && (inv_r != '0)) begin
                inv_r <= inv_r - INV_W'(1);
            end
        end
    end

    // Kills this edge, added to the score with saturation
    always_comb begin
        kill_cnt_s = '0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            kill_cnt_s = kill_cnt_s + {{SCORE_W{1'b0}}, kill_now_s[i]};
        end
        score_sum_s = {1'b0, score_r} + kill_cnt_s;
        if (score_sum_s[SCORE_W]) begin
            score_next_s = {SCORE_W{1'b1}};
        end else begin
            score_next_s = score_sum_s[SCORE_W-1:0];
        end
    end

    // Score register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_r <= '0;
        end else begin
            score_r <= score_next_s;
        end
    end

    assign bus.Enemy_Alive   = alive_s;
    assign bus.Enemy_Blood   = eblood_s;
    assign bus.Enemy_Killed  = killed_s;
    assign bus.Enemy_Respawn = respawn_s;
    assign bus.Player_Blood  = php_r;
    assign bus.Player_Invuln = (inv_r != '0);
    assign bus.Game_Over     = game_over_r;
    assign bus.Score         = score_r;

endmodule

// File: tb/tb_combat_manager.sv
// Self-checking bench for combat_manager: directed scenarios plus random
// frames, all compared against an integer-level model of the combat rules.
`timescale 1ns/1ps
module tb_combat_manager;
    localparam int EN = 4;
    localparam int CW = 9;
    localparam int HW = 7;
    localparam int SW = 10;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_clk = 1'b0;

    combat_manager_if #(.ENEMY_NUM(EN), .COORD_W(CW), .HP_W(HW), .SCORE_W(SW)) bus ();

    combat_manager dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_hp[EN];
    bit m_alive[EN];
    int m_cnt[EN];
    int m_php, m_inv, m_score;
    bit m_go;
    int exp_killed[EN], exp_resp[EN];
    int seen_killed[EN], seen_resp[EN];

    function automatic bit ov(int l1, int r1, int t1, int b1, int l2, int r2, int t2, int b2);
        return (l1 <= r2) && (r1 >= l2) && (t1 <= b2) && (b1 >= t2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < EN; i++) begin
            m_hp[i] = 100; m_alive[i] = 1'b1; m_cnt[i] = 0;
        end
        m_php = 100; m_inv = 0; m_score = 0; m_go = 1'b0;
    endtask

    // One frame of game rules, evaluated on the inputs currently driven
    task automatic model_tick();
        int ax, ay, l, r, t, b, px, py, kills;
        bit contact;
        ax = int'(bus.Attack_X); ay = int'(bus.Attack_Y);
        px = int'(bus.Player_X); py = int'(bus.Player_Y);
        l = ax; r = ax + 16; t = ay; b = ay + 80;
        case (bus.Player_Direction)
            2'd1: begin l = (ax > 80) ? ax - 80 : 0; r = ax; t = ay; b = ay + 16; end
            2'd2: begin l = ax; r = ax + 16; t = (ay > 80) ? ay - 80 : 0; b = ay; end
            2'd3: begin l = ax; r = ax + 80; t = ay; b = ay + 16; end
            default: begin l = ax; r = ax + 16; t = ay; b = ay + 80; end
        endcase
        contact = 1'b0; kills = 0;
        for (int i = 0; i < EN; i++) begin
            int exx, eyy;
            exx = int'(bus.Enemy_X[i*CW +: CW]);
            eyy = int'(bus.Enemy_Y[i*CW +: CW]);
            exp_killed[i] = 0; exp_resp[i] = 0;
            if (m_alive[i] && ov(px, px + 26, py, py + 26, exx, exx + 26, eyy, eyy + 26)) contact = 1'b1;
            if (!m_go) begin
                if (m_alive[i]) begin
                    if (bus.Attack_On && ov(l, r, t, b, exx, exx + 26, eyy, eyy + 26)) begin
                        m_hp[i] = (m_hp[i] <= 25) ? 0 : m_hp[i] - 25;
                        if (m_hp[i] == 0) begin
                            m_alive[i] = 1'b0; m_cnt[i] = 80; exp_killed[i] = 1; kills++;
                        end
                    end
                end else begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_alive[i] = 1'b1; m_hp[i] = 100; exp_resp[i] = 1;
                    end
                end
            end
        end
        if (!m_go && m_inv == 0 && contact) begin
            m_php = (m_php <= 10) ? 0 : m_php - 10;
            m_inv = 30;
            if (m_php == 0) m_go = 1'b1;
        end else if (m_inv > 0) begin
            m_inv--;
        end
        m_score = (m_score + kills > 1023) ? 1023 : m_score + kills;
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        bus.Enemy_X[i*CW +: CW] = CW'(x);
        bus.Enemy_Y[i*CW +: CW] = CW'(y);
    endtask

    task automatic park_all();
        for (int i = 0; i < EN; i++) set_enemy(i, 200 + 40 * i, 0);
        bus.Player_X = 9'd450; bus.Player_Y = 9'd450;
        bus.Attack_X = 9'd0;   bus.Attack_Y = 9'd0;
        bus.Player_Direction = 2'd0; bus.Attack_On = 1'b0;
    endtask

    task automatic apply_reset();
        frame_clk = 1'b0;
        Reset_n = 1'b0;
        park_all();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        model_reset();
    endtask

    // Pulse frame_clk, collect event pulses, then compare every output to the model
    task automatic do_tick(input int hold);
        model_tick();
        for (int i = 0; i < EN; i++) begin seen_killed[i] = 0; seen_resp[i] = 0; end
        frame_clk = 1'b1;
        repeat (hold) @(negedge Clk) begin
            for (int i = 0; i < EN; i++) begin
                seen_killed[i] += int'(bus.Enemy_Killed[i]);
                seen_resp[i]   += int'(bus.Enemy_Respawn[i]);
            end
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk) begin
            for (int i = 0; i < EN; i++) begin
                seen_killed[i] += int'(bus.Enemy_Killed[i]);
                seen_resp[i]   += int'(bus.Enemy_Respawn[i]);
            end
        end
        for (int i = 0; i < EN; i++) begin
            n_checks += 4;
            if (seen_killed[i] !== exp_killed[i]) begin
                n_fail++; $display("FAIL killed_pulse[%0d]: got %0d cycles expected %0d", i, seen_killed[i], exp_killed[i]);
            end
            if (seen_resp[i] !== exp_resp[i]) begin
                n_fail++; $display("FAIL respawn_pulse[%0d]: got %0d cycles expected %0d", i, seen_resp[i], exp_resp[i]);
            end
            if (bus.Enemy_Alive[i] !== m_alive[i]) begin
                n_fail++; $display("FAIL alive[%0d]: got %0b expected %0b", i, bus.Enemy_Alive[i], m_alive[i]);
            end
            if (int'(bus.Enemy_Blood[i*HW +: HW]) !== m_hp[i]) begin
                n_fail++; $display("FAIL enemy_blood[%0d]: got %0d expected %0d", i, bus.Enemy_Blood[i*HW +: HW], m_hp[i]);
            end
        end
        n_checks += 4;
        if (int'(bus.Player_Blood) !== m_php) begin
            n_fail++; $display("FAIL player_blood: got %0d expected %0d", bus.Player_Blood, m_php);
        end
        if (bus.Player_Invuln !== (m_inv != 0)) begin
            n_fail++; $display("FAIL player_invuln: got %0b expected %0b", bus.Player_Invuln, (m_inv != 0));
        end
        if (bus.Game_Over !== m_go) begin
            n_fail++; $display("FAIL game_over: got %0b expected %0b", bus.Game_Over, m_go);
        end
        if (int'(bus.Score) !== m_score) begin
            n_fail++; $display("FAIL score: got %0d expected %0d", bus.Score, m_score);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < EN; i++) begin
            n_checks++;
            if (bus.Enemy_Blood[i*HW +: HW] !== 7'd100) begin
                n_fail++; $display("FAIL reset_blood[%0d]: got %0d expected 100", i, bus.Enemy_Blood[i*HW +: HW]);
            end
        end
        n_checks += 5;
        if (bus.Enemy_Alive !== 4'b1111) begin n_fail++; $display("FAIL reset_alive: got %b expected 1111", bus.Enemy_Alive); end
        if (bus.Score !== 10'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", bus.Score); end
        if (bus.Game_Over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", bus.Game_Over); end
        if (bus.Player_Blood !== 7'd100) begin n_fail++; $display("FAIL reset_player_blood: got %0d expected 100", bus.Player_Blood); end
        if ({bus.Enemy_Killed, bus.Enemy_Respawn, bus.Player_Invuln} !== 9'd0) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0", {bus.Enemy_Killed, bus.Enemy_Respawn, bus.Player_Invuln});
        end
    endtask

    task automatic test_attack_right();
        int exp_b[3] = '{50, 25, 0};
        bus.Player_Direction = 2'd3; bus.Attack_X = 9'd100; bus.Attack_Y = 9'd100;
        set_enemy(0, 150, 105);
        bus.Attack_On = 1'b1;
        repeat (1000) @(negedge Clk);
        n_checks++;
        if (bus.Enemy_Blood[HW-1:0] !== 7'd100) begin n_fail++; $display("FAIL no_tick_no_damage: got %0d expected 100", bus.Enemy_Blood[HW-1:0]); end
        do_tick(1000);
        n_checks++;
        if (bus.Enemy_Blood[HW-1:0] !== 7'd75) begin n_fail++; $display("FAIL long_tick_single_hit: got %0d expected 75", bus.Enemy_Blood[HW-1:0]); end
        for (int k = 0; k < 3; k++) begin
            do_tick(4);
            n_checks++;
            if (int'(bus.Enemy_Blood[HW-1:0]) !== exp_b[k]) begin
                n_fail++; $display("FAIL attack_step%0d: got %0d expected %0d", k, bus.Enemy_Blood[HW-1:0], exp_b[k]);
            end
        end
        n_checks += 3;
        if (seen_killed[0] !== 1) begin n_fail++; $display("FAIL kill_pulse0: got %0d expected 1", seen_killed[0]); end
        if (bus.Score !== 10'd1) begin n_fail++; $display("FAIL kill_score: got %0d expected 1", bus.Score); end
        if (bus.Enemy_Alive[0] !== 1'b0) begin n_fail++; $display("FAIL kill_alive0: got %b expected 0", bus.Enemy_Alive[0]); end
    endtask

    task automatic test_respawn();
        bus.Attack_On = 1'b0;
        repeat (79) do_tick(4);
        n_checks++;
        if (bus.Enemy_Alive[0] !== 1'b0) begin n_fail++; $display("FAIL respawn_79: got %b expected 0", bus.Enemy_Alive[0]); end
        do_tick(4);
        n_checks += 3;
        if (bus.Enemy_Alive[0] !== 1'b1) begin n_fail++; $display("FAIL respawn_80_alive: got %b expected 1", bus.Enemy_Alive[0]); end
        if (bus.Enemy_Blood[HW-1:0] !== 7'd100) begin n_fail++; $display("FAIL respawn_80_blood: got %0d expected 100", bus.Enemy_Blood[HW-1:0]); end
        if (seen_resp[0] !== 1) begin n_fail++; $display("FAIL respawn_pulse0: got %0d expected 1", seen_resp[0]); end
    endtask

    task automatic test_left_clamp();
        park_all();
        bus.Player_Direction = 2'd1; bus.Attack_X = 9'd40; bus.Attack_Y = 9'd100;
        set_enemy(1, 0, 100);
        bus.Attack_On = 1'b1;
        do_tick(4);
        n_checks++;
        if (bus.Enemy_Blood[HW +: HW] !== 7'd75) begin n_fail++; $display("FAIL left_clamp_hit: got %0d expected 75", bus.Enemy_Blood[HW +: HW]); end
        bus.Attack_X = 9'd200;
        set_enemy(1, 240, 0);
        set_enemy(2, 94, 100);
        set_enemy(3, 93, 100);
        do_tick(4);
        n_checks += 2;
        if (bus.Enemy_Blood[2*HW +: HW] !== 7'd75) begin n_fail++; $display("FAIL edge_touch_hit: got %0d expected 75", bus.Enemy_Blood[2*HW +: HW]); end
        if (bus.Enemy_Blood[3*HW +: HW] !== 7'd100) begin n_fail++; $display("FAIL edge_gap_miss: got %0d expected 100", bus.Enemy_Blood[3*HW +: HW]); end
    endtask

    task automatic test_double_kill();
        park_all();
        bus.Player_Direction = 2'd0; bus.Attack_X = 9'd300; bus.Attack_Y = 9'd200;
        set_enemy(1, 290, 210);
        set_enemy(2, 310, 250);
        bus.Attack_On = 1'b1;
        repeat (2) do_tick(4);
        n_checks++;
        if ({bus.Enemy_Blood[HW +: HW], bus.Enemy_Blood[2*HW +: HW]} !== {7'd25, 7'd25}) begin
            n_fail++; $display("FAIL double_pre: got %0d,%0d expected 25,25", bus.Enemy_Blood[HW +: HW], bus.Enemy_Blood[2*HW +: HW]);
        end
        do_tick(4);
        n_checks += 2;
        if (bus.Score !== 10'd3) begin n_fail++; $display("FAIL double_score: got %0d expected 3", bus.Score); end
        if (bus.Enemy_Alive[2:1] !== 2'b00) begin n_fail++; $display("FAIL double_alive: got %b expected 00", bus.Enemy_Alive[2:1]); end
    endtask

    task automatic test_contact_gameover();
        int guard;
        park_all();
        set_enemy(3, 450, 450);
        do_tick(4);
        n_checks += 2;
        if (bus.Player_Blood !== 7'd90) begin n_fail++; $display("FAIL contact_t1: got %0d expected 90", bus.Player_Blood); end
        if (bus.Player_Invuln !== 1'b1) begin n_fail++; $display("FAIL contact_invuln: got %b expected 1", bus.Player_Invuln); end
        repeat (30) do_tick(4);
        n_checks++;
        if (bus.Player_Blood !== 7'd90) begin n_fail++; $display("FAIL contact_t31: got %0d expected 90", bus.Player_Blood); end
        do_tick(4);
        n_checks++;
        if (bus.Player_Blood !== 7'd80) begin n_fail++; $display("FAIL contact_t32: got %0d expected 80", bus.Player_Blood); end
        guard = 0;
        while (m_php > 10 && guard < 400) begin do_tick(4); guard++; end
        // kill slot 0 shortly before the final hit so its respawn is pending at game over
        set_enemy(3, 320, 0);
        bus.Player_Direction = 2'd3; bus.Attack_X = 9'd100; bus.Attack_Y = 9'd100;
        set_enemy(0, 150, 105);
        bus.Attack_On = 1'b1;
        repeat (4) do_tick(4);
        bus.Attack_On = 1'b0;
        set_enemy(3, 450, 450);
        guard = 0;
        while (!m_go && guard < 40) begin do_tick(4); guard++; end
        n_checks += 2;
        if (bus.Game_Over !== 1'b1) begin n_fail++; $display("FAIL game_over_set: got %b expected 1", bus.Game_Over); end
        if (bus.Player_Blood !== 7'd0) begin n_fail++; $display("FAIL game_over_blood: got %0d expected 0", bus.Player_Blood); end
        set_enemy(1, 150, 105);
        bus.Attack_On = 1'b1;
        repeat (100) do_tick(4);
        n_checks += 2;
        if (bus.Enemy_Alive[0] !== 1'b0) begin n_fail++; $display("FAIL respawn_frozen: got %b expected 0", bus.Enemy_Alive[0]); end
        if (bus.Game_Over !== 1'b1) begin n_fail++; $display("FAIL game_over_sticky: got %b expected 1", bus.Game_Over); end
        apply_reset();
        n_checks += 2;
        if (bus.Game_Over !== 1'b0) begin n_fail++; $display("FAIL reset_clears_go: got %b expected 0", bus.Game_Over); end
        if (bus.Enemy_Alive !== 4'b1111) begin n_fail++; $display("FAIL reset_aborts_respawn: got %b expected 1111", bus.Enemy_Alive); end
    endtask

    task automatic test_reset_abort_invuln();
        set_enemy(3, 450, 450);
        do_tick(4);
        apply_reset();
        n_checks++;
        if (bus.Player_Invuln !== 1'b0) begin n_fail++; $display("FAIL reset_aborts_invuln: got %b expected 0", bus.Player_Invuln); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < EN; i++) set_enemy(i, int'($urandom_range(220, 60)), int'($urandom_range(220, 60)));
            bus.Player_X = CW'($urandom_range(220, 60));
            bus.Player_Y = CW'($urandom_range(220, 60));
            bus.Attack_X = CW'($urandom_range(220, 60));
            bus.Attack_Y = CW'($urandom_range(220, 60));
            bus.Player_Direction = 2'($urandom_range(3, 0));
            bus.Attack_On = 1'($urandom_range(1, 0));
            do_tick(int'($urandom_range(8, 4)));
        end
    endtask

    initial begin
        park_all();
        model_reset();
        test_reset();
        test_attack_right();
        test_respawn();
        test_left_clamp();
        test_double_kill();
        test_contact_gameover();
        test_reset_abort_invuln();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
